// File: rtl/audio_pkg.sv
// Shared types for the audio source arbiter: default sample width, {L,R} frame, FSM states.
package audio_pkg;

    localparam int AUDIO_WIDTH_DFLT = 16;

    typedef logic [2*AUDIO_WIDTH_DFLT-1:0] frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/audio_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr+1, wrapping.
module audio_rr_picker #(
    parameter int NUM_SRC = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [PW-1:0]      index,
    output logic               any
);

    logic [PW-1:0] w_cand;

    // Scan from farthest to nearest so the nearest requester after ptr overwrites last.
    always_comb begin
        gnt    = '0;
        index  = '0;
        w_cand = '0;
        for (int unsigned k = NUM_SRC; k >= 1; k--) begin
            w_cand = PW'((32'(ptr) + k) % NUM_SRC);
            if (req[w_cand]) begin
                gnt         = '0;
                gnt[w_cand] = 1'b1;
                index       = w_cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/audio_src_arbiter.sv
// Round-robin arbiter of NUM_SRC stereo sources into one audio FIFO write port.
// Optional idle silence-frame insertion when AUDIO_ARB_SILENCE_EN is defined.
module audio_src_arbiter
    import audio_pkg::*;
#(
    parameter int AUDIO_WIDTH = AUDIO_WIDTH_DFLT,
    parameter int NUM_SRC     = 4,
    parameter int BURST       = 8,
    parameter int SILENCE_GAP = 1000
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_SRC*2*AUDIO_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC-1:0]             src_mask,
    output logic [2*AUDIO_WIDTH-1:0]       out_data,
    output logic                           out_en,
    input  logic                           out_full,
    output logic [NUM_SRC-1:0]             grant,
    output logic                           busy
);

    localparam int FW = 2 * AUDIO_WIDTH;
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
    localparam logic [PW-1:0] PTR_RST    = PW'(NUM_SRC - 1);

    state_t               r_state, w_state_nxt;
    logic [NUM_SRC-1:0]   r_grant, w_grant_nxt;
    logic [PW-1:0]        r_gidx, w_gidx_nxt;
    logic [PW-1:0]        r_ptr, w_ptr_nxt;
    logic [BW-1:0]        r_burst, w_burst_nxt;
    logic                 r_out_en, w_out_en_nxt;
    logic [FW-1:0]        r_out_data, w_out_data_nxt;

    logic [FW-1:0]        w_frame [NUM_SRC];
    logic [NUM_SRC-1:0]   w_req;
    logic [NUM_SRC-1:0]   w_pick_gnt;
    logic [PW-1:0]        w_pick_idx;
    logic                 w_pick_any;
    logic                 w_xfer;
    logic                 w_release;

`ifdef AUDIO_ARB_SILENCE_EN
    localparam int SW = (SILENCE_GAP > 1) ? $clog2(SILENCE_GAP) : 1;
    localparam logic [SW-1:0] SIL_LAST = SW'(SILENCE_GAP - 1);
    logic [SW-1:0]        r_sil, w_sil_nxt;
`else
    logic                 w_unused_gap;
    assign w_unused_gap = (SILENCE_GAP != 0);
`endif

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign w_frame[g] = src_data[g*FW +: FW];
    end

    assign w_req = src_valid & src_mask;

    audio_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .PW      (PW)
    ) u_picker (
        .req   (w_req),
        .ptr   (r_ptr),
        .gnt   (w_pick_gnt),
        .index (w_pick_idx),
        .any   (w_pick_any)
    );

    // Mask is folded into ready, so a same-cycle mask drop blocks the transfer and releases.
    assign src_ready = (r_state == SERVE && !out_full) ? (r_grant & src_mask) : '0;
    assign w_xfer    = |(src_ready & src_valid);
    assign w_release = (r_state == SERVE) &&
                       ((w_xfer && r_burst == BURST_LAST) ||
                        !src_valid[r_gidx] || !src_mask[r_gidx]);

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_gidx_nxt     = r_gidx;
        w_ptr_nxt      = r_ptr;
        w_burst_nxt    = r_burst;
        w_out_en_nxt   = 1'b0;
        w_out_data_nxt = r_out_data;
`ifdef AUDIO_ARB_SILENCE_EN
        w_sil_nxt      = '0;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = SERVE;
                    w_grant_nxt = w_pick_gnt;
                    w_gidx_nxt  = w_pick_idx;
                    w_burst_nxt = '0;
                end
`ifdef AUDIO_ARB_SILENCE_EN
                else if (!out_full) begin
                    if (r_sil == SIL_LAST) begin
                        w_out_en_nxt   = 1'b1;
                        w_out_data_nxt = '0;
                    end else begin
                        w_sil_nxt = r_sil + 1'b1;
                    end
                end
`endif
            end
            SERVE: begin
                if (w_xfer) begin
                    w_out_en_nxt   = 1'b1;
                    w_out_data_nxt = w_frame[r_gidx];
                    w_burst_nxt    = r_burst + 1'b1;
                end
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = r_gidx;
                    w_grant_nxt = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_ptr      <= PTR_RST;
            r_burst    <= '0;
            r_out_en   <= 1'b0;
            r_out_data <= '0;
`ifdef AUDIO_ARB_SILENCE_EN
            r_sil      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_gidx     <= w_gidx_nxt;
            r_ptr      <= w_ptr_nxt;
            r_burst    <= w_burst_nxt;
            r_out_en   <= w_out_en_nxt;
            r_out_data <= w_out_data_nxt;
`ifdef AUDIO_ARB_SILENCE_EN
            r_sil      <= w_sil_nxt;
`endif
        end
    end

    assign out_en   = r_out_en;
    assign out_data = r_out_data;
    assign grant    = r_grant;
    assign busy     = (r_state == SERVE);

endmodule
